// File: rtl/pref_issue_queue.sv
// Prefetch issue queue: block-aligns up to three prefetch candidates per cycle,
// drops candidates that duplicate queued, recently issued or earlier same-cycle
// blocks, buffers survivors in a FIFO and issues them one per cycle over a
// valid/ready handshake. Issued blocks are remembered in a small round-robin
// filter so that re-requests shortly after issue are suppressed.
module pref_issue_queue #(
    parameter int DEPTH           = 8,
    parameter int FILTER_ENTRIES  = 16,
    parameter int ADDR_W          = 64,
    parameter int LOG2_BLOCK_SIZE = 6,
    parameter int CNT_W           = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic [ADDR_W-1:0]        pref_addr1_i,
    input  logic                     pref_valid1_i,
    input  logic [ADDR_W-1:0]        pref_addr2_i,
    input  logic                     pref_valid2_i,
    input  logic [ADDR_W-1:0]        pref_addr3_i,
    input  logic                     pref_valid3_i,
    output logic [ADDR_W-1:0]        req_addr_o,
    output logic                     req_valid_o,
    input  logic                     req_ready_i,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic [CNT_W-1:0]         dup_drop_count_o,
    output logic [CNT_W-1:0]         ovf_drop_count_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int FPTR_W = $clog2(FILTER_ENTRIES);

    // Clear the byte-offset bits so that all storage and compares work on blocks.
    function automatic logic [ADDR_W-1:0] align_blk(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:LOG2_BLOCK_SIZE], {LOG2_BLOCK_SIZE{1'b0}}};
    endfunction

    // Saturating add of a small per-cycle increment (0..3) to a drop counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // FIFO storage and control
    logic [ADDR_W-1:0]         fifo_q [DEPTH];
    logic [PTR_W-1:0]          head_q, head_d;
    logic [PTR_W-1:0]          tail_q, tail_d;
    logic [OCC_W-1:0]          occ_q, occ_d;

    // Recently-issued filter
    logic [ADDR_W-1:0]         filt_q [FILTER_ENTRIES];
    logic [FILTER_ENTRIES-1:0] fvld_q, fvld_d;
    logic [FPTR_W-1:0]         fwp_q, fwp_d;

    // Drop counters
    logic [CNT_W-1:0]          dup_cnt_q, dup_cnt_d;
    logic [CNT_W-1:0]          ovf_cnt_q, ovf_cnt_d;

    // Candidate evaluation
    logic [ADDR_W-1:0]         cand_blk [3];
    logic [2:0]                cand_vld;
    logic [DEPTH-1:0]          ent_vld;
    logic [2:0]                base_hit;
    logic                      nd0, nd1, nd2;
    logic                      acc0, acc1, acc2;
    logic [1:0]                pos1, pos2;
    logic [OCC_W-1:0]          free;
    logic [1:0]                enq_n, nd_n, ovf_n, dup_n;
    logic                      issue;

    // Offset bits never take part in any decision.
    logic                      unused_offsets;
    assign unused_offsets = ^{pref_addr1_i[LOG2_BLOCK_SIZE-1:0],
                              pref_addr2_i[LOG2_BLOCK_SIZE-1:0],
                              pref_addr3_i[LOG2_BLOCK_SIZE-1:0]};

    assign cand_blk[0] = align_blk(pref_addr1_i);
    assign cand_blk[1] = align_blk(pref_addr2_i);
    assign cand_blk[2] = align_blk(pref_addr3_i);
    assign cand_vld    = {pref_valid3_i, pref_valid2_i, pref_valid1_i};

    // Mark which FIFO slots currently hold live entries (head included).
    always_comb begin
        ent_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_vld[i] = ({1'b0, PTR_W'(i) - head_q} < occ_q);
        end
    end

    // Match each candidate against live FIFO entries and the issued-block filter.
    always_comb begin
        base_hit = '0;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_vld[i] && (fifo_q[i] == cand_blk[j])) begin
                    base_hit[j] = 1'b1;
                end
            end
            for (int f = 0; f < FILTER_ENTRIES; f++) begin
                if (fvld_q[f] && (filt_q[f] == cand_blk[j])) begin
                    base_hit[j] = 1'b1;
                end
            end
        end
    end

    // A candidate is new only if no earlier new candidate (accepted or
    // overflow-dropped) in this cycle carried the same block.
    assign nd0 = cand_vld[0] & ~base_hit[0];
    assign nd1 = cand_vld[1] & ~base_hit[1]
               & ~(nd0 & (cand_blk[1] == cand_blk[0]));
    assign nd2 = cand_vld[2] & ~base_hit[2]
               & ~(nd0 & (cand_blk[2] == cand_blk[0]))
               & ~(nd1 & (cand_blk[2] == cand_blk[1]));

    // Space is judged on start-of-cycle occupancy; a same-cycle pop does not help.
    assign free = OCC_W'(DEPTH) - occ_q;
    assign pos1 = {1'b0, nd0};
    assign pos2 = {1'b0, nd0} + {1'b0, nd1};
    assign acc0 = nd0 & (free != '0);
    assign acc1 = nd1 & (OCC_W'(pos1) < free);
    assign acc2 = nd2 & (OCC_W'(pos2) < free);

    assign enq_n = {1'b0, acc0} + {1'b0, acc1} + {1'b0, acc2};
    assign nd_n  = {1'b0, nd0} + {1'b0, nd1} + {1'b0, nd2};
    assign ovf_n = nd_n - enq_n;
    assign dup_n = {1'b0, cand_vld[0] & ~nd0} + {1'b0, cand_vld[1] & ~nd1}
                 + {1'b0, cand_vld[2] & ~nd2};

    assign issue = (occ_q != '0) & req_ready_i & ~flush_i;

    // Next-state for pointers, occupancy, filter bookkeeping and counters.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        occ_d     = occ_q;
        fvld_d    = fvld_q;
        fwp_d     = fwp_q;
        dup_cnt_d = dup_cnt_q;
        ovf_cnt_d = ovf_cnt_q;
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (issue) begin
                head_d        = head_q + PTR_W'(1);
                fvld_d[fwp_q] = 1'b1;
                fwp_d         = fwp_q + FPTR_W'(1);
            end
            tail_d    = tail_q + PTR_W'(enq_n);
            occ_d     = occ_q + OCC_W'(enq_n) - OCC_W'(issue);
            dup_cnt_d = sat_add(dup_cnt_q, dup_n);
            ovf_cnt_d = sat_add(ovf_cnt_q, ovf_n);
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            occ_q     <= '0;
            fvld_q    <= '0;
            fwp_q     <= '0;
            dup_cnt_q <= '0;
            ovf_cnt_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            occ_q     <= occ_d;
            fvld_q    <= fvld_d;
            fwp_q     <= fwp_d;
            dup_cnt_q <= dup_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    // FIFO payload writes; accepted candidates land in consecutive slots from tail.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i) begin
            if (acc0) fifo_q[tail_q]                 <= cand_blk[0];
            if (acc1) fifo_q[tail_q + PTR_W'(pos1)]  <= cand_blk[1];
            if (acc2) fifo_q[tail_q + PTR_W'(pos2)]  <= cand_blk[2];
        end
    end

    // Record the issued block over the oldest filter entry.
    always_ff @(posedge clk) begin
        if (!rst && issue) begin
            filt_q[fwp_q] <= fifo_q[head_q];
        end
    end

    assign req_valid_o      = (occ_q != '0);
    assign req_addr_o       = req_valid_o ? fifo_q[head_q] : '0;
    assign occupancy_o      = occ_q;
    assign dup_drop_count_o = dup_cnt_q;
    assign ovf_drop_count_o = ovf_cnt_q;

endmodule

// File: tb/tb_pref_issue_queue.sv
// Bench for pref_issue_queue: directed scenarios followed by a random phase,
// all checked against a queue-based reference model of the queue behaviour.
module tb_pref_issue_queue;

    localparam int DEPTH = 8;
    localparam int FENT  = 16;
    localparam int AW    = 64;
    localparam int CW    = 5;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [AW-1:0] a1, a2, a3;
    logic          v1, v2, v3;
    logic          ready;
    logic [AW-1:0] req_addr;
    logic          req_valid;
    logic [3:0]    occ;
    logic [CW-1:0] dup_cnt, ovf_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [AW-1:0] mq[$];
    logic [AW-1:0] mf[FENT];
    bit            mfv[FENT];
    int            mwp;
    int            mdup, movf;

    pref_issue_queue #(
        .DEPTH(DEPTH), .FILTER_ENTRIES(FENT), .ADDR_W(AW),
        .LOG2_BLOCK_SIZE(6), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .pref_addr1_i(a1), .pref_valid1_i(v1),
        .pref_addr2_i(a2), .pref_valid2_i(v2),
        .pref_addr3_i(a3), .pref_valid3_i(v3),
        .req_addr_o(req_addr), .req_valid_o(req_valid), .req_ready_i(ready),
        .occupancy_o(occ), .dup_drop_count_o(dup_cnt), .ovf_drop_count_o(ovf_cnt)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one clock edge of the specified rules to the model.
    task automatic model_step();
        logic [AW-1:0] ca[3];
        bit            cv[3];
        logic [AW-1:0] seen[$];
        logic [AW-1:0] newq[$];
        int            free, enq;
        bit            dup;
        ca[0] = a1 & ~64'h3F; ca[1] = a2 & ~64'h3F; ca[2] = a3 & ~64'h3F;
        cv[0] = v1; cv[1] = v2; cv[2] = v3;
        if (rst) begin
            mq.delete();
            for (int f = 0; f < FENT; f++) mfv[f] = 0;
            mwp = 0; mdup = 0; movf = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            free = DEPTH - mq.size();
            enq  = 0;
            for (int j = 0; j < 3; j++) begin
                if (cv[j]) begin
                    dup = 0;
                    foreach (mq[k]) if (mq[k] == ca[j]) dup = 1;
                    for (int f = 0; f < FENT; f++) if (mfv[f] && mf[f] == ca[j]) dup = 1;
                    foreach (seen[k]) if (seen[k] == ca[j]) dup = 1;
                    if (dup) mdup = sat(mdup + 1);
                    else begin
                        seen.push_back(ca[j]);
                        if (enq < free) begin newq.push_back(ca[j]); enq++; end
                        else movf = sat(movf + 1);
                    end
                end
            end
            if (mq.size() != 0 && ready) begin
                mf[mwp]  = mq.pop_front();
                mfv[mwp] = 1;
                mwp      = (mwp + 1) % FENT;
            end
            foreach (newq[k]) mq.push_back(newq[k]);
        end
    endtask

    task automatic check_all();
        chk("req_valid", 64'(req_valid), 64'(mq.size() != 0));
        chk("req_addr",  req_addr, (mq.size() != 0) ? mq[0] : 64'h0);
        chk("occupancy", 64'(occ), 64'(mq.size()));
        chk("dup_count", 64'(dup_cnt), 64'(mdup));
        chk("ovf_count", 64'(ovf_cnt), 64'(movf));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic setc(input logic iv1, input logic [AW-1:0] ia1,
                        input logic iv2, input logic [AW-1:0] ia2,
                        input logic iv3, input logic [AW-1:0] ia3);
        v1 = iv1; a1 = ia1; v2 = iv2; a2 = ia2; v3 = iv3; a3 = ia3;
    endtask

    task automatic idle();
        setc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int sdup, sovf;
        rst = 1; flush = 0; ready = 1;
        mwp = 0; mdup = 0; movf = 0;
        for (int f = 0; f < FENT; f++) begin mfv[f] = 0; mf[f] = '0; end

        // Reset with all candidates valid
        setc(1, 64'h1111, 1, 64'h2222, 1, 64'h3333);
        step(); step();
        chk("rst_valid", 64'(req_valid), 64'h0);
        chk("rst_occ",   64'(occ), 64'h0);
        chk("rst_dup",   64'(dup_cnt), 64'h0);
        chk("rst_ovf",   64'(ovf_cnt), 64'h0);
        rst = 0;

        // Single candidate, held while not ready, then popped
        ready = 0;
        setc(1, 64'h1004, 0, 0, 0, 0);
        step();
        chk("single_valid", 64'(req_valid), 64'h1);
        chk("single_addr",  req_addr, 64'h1000);
        chk("single_occ",   64'(occ), 64'h1);
        idle();
        step();
        chk("single_hold", req_addr, 64'h1000);
        ready = 1;
        step();
        chk("single_pop", 64'(occ), 64'h0);

        // Same-cycle duplicate
        ready = 0;
        setc(1, 64'h2010, 1, 64'h2038, 1, 64'h2040);
        step();
        chk("samecyc_occ",  64'(occ), 64'h2);
        chk("samecyc_dup",  64'(dup_cnt), 64'h1);
        chk("samecyc_head", req_addr, 64'h2000);
        idle(); ready = 1;
        step();
        chk("samecyc_second", req_addr, 64'h2040);
        step();

        // Overflow
        ready = 0;
        setc(1, 64'h000, 1, 64'h040, 1, 64'h080); step();
        setc(1, 64'h0C0, 1, 64'h100, 1, 64'h140); step();
        setc(1, 64'h180, 1, 64'h1C0, 1, 64'h200); step();
        chk("ovf_occ", 64'(occ), 64'h8);
        chk("ovf_cnt", 64'(ovf_cnt), 64'h1);
        idle(); ready = 1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain_addr", req_addr, 64'(i * 64));
            step();
        end
        chk("ovf_absent", 64'(req_valid), 64'h0);

        // Filter hit and eviction
        setc(1, 64'h3000, 0, 0, 0, 0); step();
        idle(); step();
        chk("filt_issued", 64'(occ), 64'h0);
        setc(1, 64'h3000, 0, 0, 0, 0); step();
        chk("filt_hit_dup", 64'(dup_cnt), 64'h2);
        chk("filt_hit_occ", 64'(occ), 64'h0);
        for (int k = 0; k < 16; k++) begin
            setc(1, 64'h4000 + 64'(k * 64), 0, 0, 0, 0);
            step();
        end
        idle(); step();
        chk("filt_16_issued", 64'(occ), 64'h0);
        setc(1, 64'h3000, 0, 0, 0, 0); step();
        chk("filt_evict_occ",  64'(occ), 64'h1);
        chk("filt_evict_addr", req_addr, 64'h3000);
        idle(); step();

        // Flush
        ready = 0;
        setc(1, 64'h6000, 1, 64'h6040, 1, 64'h6080); step();
        setc(1, 64'h60C0, 1, 64'h6100, 0, 0); step();
        chk("flush_pre_occ", 64'(occ), 64'h5);
        sdup = int'(dup_cnt); sovf = int'(ovf_cnt);
        flush = 1; ready = 1;
        setc(1, 64'h5000, 0, 0, 0, 0); step();
        flush = 0;
        chk("flush_occ",   64'(occ), 64'h0);
        chk("flush_valid", 64'(req_valid), 64'h0);
        chk("flush_dup",   64'(dup_cnt), 64'(sdup));
        chk("flush_ovf",   64'(ovf_cnt), 64'(sovf));
        ready = 0;
        setc(1, 64'h6000, 1, 64'h3000, 1, 64'h5000); step();
        chk("flush_filt_occ", 64'(occ), 64'h2);
        chk("flush_filt_dup", 64'(dup_cnt), 64'(sdup + 1));
        chk("flush_filt_head", req_addr, 64'h6000);

        // Random phase against the model
        for (int c = 0; c < 2000; c++) begin
            v1 = ($urandom_range(0, 9) < 6);
            v2 = ($urandom_range(0, 9) < 5);
            v3 = ($urandom_range(0, 9) < 4);
            a1 = 64'h10000 + 64'($urandom_range(0, 47) * 64 + $urandom_range(0, 63));
            a2 = 64'h10000 + 64'($urandom_range(0, 47) * 64 + $urandom_range(0, 63));
            a3 = 64'h10000 + 64'($urandom_range(0, 47) * 64 + $urandom_range(0, 63));
            ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 39) == 0);
            rst   = (c == 1000);
            step();
        end
        rst = 0; flush = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pref_issue_queue.md
Name: pref_issue_queue

Overview:
- Sits directly downstream of the IP-stride prefetcher.
- Each cycle, accepts up to three prefetch candidates (degree 3), aligns them to cache blocks, and removes duplicates.
- Duplicates are checked against queued entries, recently issued blocks and earlier candidates in the same cycle.
- Survivors are buffered in a FIFO and issued one per cycle to the L1/L2 prefetch port over a valid/ready handshake.

Parameters:
- DEPTH, 8, issue FIFO entries; power of two, ≥4.
- FILTER_ENTRIES, 16, recently-issued block filter entries; power of two.
- ADDR_W, 64, address width.
- LOG2_BLOCK_SIZE, 6, log2 of cache block bytes.
- CNT_W, 16, width of the drop counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush_i  in  1  clear FIFO contents (filter retained)
- pref_addr1_i  in  ADDR_W  candidate 1 byte address
- pref_valid1_i  in  1  candidate 1 valid
- pref_addr2_i  in  ADDR_W  candidate 2 byte address
- pref_valid2_i  in  1  candidate 2 valid
- pref_addr3_i  in  ADDR_W  candidate 3 byte address
- pref_valid3_i  in  1  candidate 3 valid
- req_addr_o  out  ADDR_W  block-aligned prefetch request address
- req_valid_o  out  1  request valid
- req_ready_i  in  1  cache accepts request
- occupancy_o  out  $clog2(DEPTH)+1  current FIFO entry count
- dup_drop_count_o  out  CNT_W  saturating count of duplicate drops
- ovf_drop_count_o  out  CNT_W  saturating count of overflow drops

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO emptied; all filter entries invalidated; filter write pointer cleared to 0.
  - Both counters cleared to 0.
  - req_valid_o=0, req_addr_o=0, occupancy_o=0.
  - rst overrides flush_i and all candidates.
- Alignment: candidate block = addr with bits [LOG2_BLOCK_SIZE-1:0] cleared. All comparisons and storage use the aligned value.
- Candidate evaluation, in order 1, 2, 3; only valid candidates are considered. A candidate is a duplicate if its block equals any of:
  - (a) a valid FIFO entry, including the head being issued this cycle;
  - (b) a valid filter entry;
  - (c) an earlier candidate in the same cycle that was accepted or dropped for overflow.
- Duplicate handling: duplicates are dropped and each one increments dup_drop_count_o.
- Enqueue capacity:
  - free = DEPTH - occupancy at the start of the cycle. A dequeue in the same cycle does not add space.
  - Non-duplicate candidates are enqueued in order while free remains.
  - Each non-duplicate beyond free is dropped and increments ovf_drop_count_o.
  - A maximum of 3 entries are enqueued per cycle.
- Counters saturate at 2^CNT_W-1. A single cycle may add up to 3 to one counter.
- Latency: a candidate accepted at edge N is visible on req_addr_o/req_valid_o after edge N if the FIFO was empty. It is never combinationally forwarded.
- Output handshake:
  - req_valid_o = (occupancy != 0); req_addr_o = head entry.
  - Issue occurs when req_valid_o & req_ready_i at posedge: the head is popped.
  - The issued block is written to the filter at the write pointer, overwriting the oldest entry; the pointer then increments, wrapping modulo FILTER_ENTRIES.
  - While req_valid_o=1 and req_ready_i=0, req_addr_o holds stable.
- Simultaneous issue and enqueue in one cycle:
  - occupancy_next = occupancy - 1 + enqueued.
  - The filter update is visible to candidates from the next cycle. Within the same cycle, the head is still covered by rule (a).
- Flush (flush_i=1, rst=0):
  - FIFO emptied at the posedge; same-cycle candidates are discarded without counting.
  - No issue occurs that cycle, even if req_ready_i=1, and the filter is not written.
  - Filter contents and counters are unchanged.
- Pointers: head and tail wrap modulo DEPTH; occupancy never exceeds DEPTH.

Test Plan:
- Reset: rst=1 for 2 cycles with all valids=1 -> req_valid_o=0, occupancy_o=0, both counters 0.
- Single candidate: pref_addr1_i=0x1004 valid, req_ready_i=0 -> next cycle req_valid_o=1, req_addr_o=0x1000, occupancy_o=1; held until ready=1, then popped and occupancy_o=0.
- Same-cycle duplicate: addr1=0x2010, addr2=0x2038, addr3=0x2040 all valid -> FIFO gets 0x2000 then 0x2040, occupancy_o=2, dup_drop_count_o=1.
- Overflow: ready=0; cycle 1 addrs 0x000/0x040/0x080, cycle 2 0x0C0/0x100/0x140, cycle 3 0x180/0x1C0/0x200 -> occupancy_o=8, ovf_drop_count_o=1, 0x200 absent.
- Filter hit and eviction: issue 0x3000 with ready=1, then present 0x3000 -> dropped, dup_drop_count_o +1. After 16 further distinct issues, 0x3000 is accepted again.
- Flush: FIFO holding 5 entries, flush_i=1 with ready=1 and addr1=0x5000 valid -> next cycle occupancy_o=0, req_valid_o=0, counters unchanged, filter unchanged.
